decoder_2to4_3to8: RTL and testbench
====================================

DECODER_2TO4_3TO8 -- requirements
Module: decoder_2to4_3to8

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter REG_OUT, default 1, meaning: 1 = registered 32-bit output path present, 0 = q32 tied to 32'h0000_0000 and q32_valid tied to 0.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1, meaning: single clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning: synchronous, active-low reset; sampled on rising clk; 0 = reset asserted.
REQ-004 The block SHALL have port sel2, input, 2, meaning: 2:4 decoder select.
REQ-005 The block SHALL have port en2, input, 1, meaning: 2:4 decoder enable.
REQ-006 The block SHALL have port d4, output, 4, meaning: 2:4 decoded one-hot output, combinational.
REQ-007 The block SHALL have port sel3, input, 3, meaning: 3:8 decoder select.
REQ-008 The block SHALL have port en3, input, 1, meaning: 3:8 decoder enable.
REQ-009 The block SHALL have port d8, output, 8, meaning: 3:8 decoded one-hot output, combinational.
REQ-010 The block SHALL have port sel5, input, 5, meaning: cascaded 5:32 select.
REQ-011 The block SHALL have port en5, input, 1, meaning: cascaded 5:32 enable.
REQ-012 The block SHALL have port d32, output, 32, meaning: cascaded 5:32 decoded output, combinational.
REQ-013 The block SHALL have port load, input, 1, meaning: capture d32 into q32 on the next rising clk.
REQ-014 The block SHALL have port q32, output, 32, meaning: registered copy of d32.
REQ-015 The block SHALL have port q32_valid, output, 1, meaning: q32 holds captured data.

Function
REQ-016 The d4 output SHALL be (1 << sel2) when en2=1, and 4'b0000 when en2=0; it is purely combinational and unaffected by reset.
REQ-017 The d8 output SHALL be (1 << sel3) when en3=1, and 8'h00 when en3=0; it is purely combinational and unaffected by reset.
REQ-018 The d32 output SHALL be built as a cascade: en_mid[3:0] = 2:4 decode of sel5[4:3] gated by en5; d32[8i+7:8i] = 3:8 decode of sel5[2:0] gated by en_mid[i], for i = 0..3.
REQ-019 Net result of REQ-018: d32 SHALL equal 32'h1 << sel5 when en5=1, and 32'h0 when en5=0; d32 is at most one-hot for every input combination.
REQ-020 The 2:4 and 3:8 stages SHALL be implemented as reusable sub-decoder logic shared by the standalone paths (d4, d8) and the cascade (d32).
REQ-021 The three decode paths SHALL be fully independent of each other: no cross-coupling of selects or enables.
REQ-022 The combinational paths SHALL have zero-cycle latency, with no X on outputs for known inputs.
REQ-023 When REG_OUT=1 and reset=1, on a rising clk with load=1, q32 SHALL take the value of d32 and q32_valid SHALL become 1.
REQ-024 When REG_OUT=1 and reset=1, on a rising clk with load=0, q32 and q32_valid SHALL hold their values.
REQ-025 The registered path SHALL have 1-cycle latency from load to q32.
REQ-026 A load with en5=0 SHALL capture 32'h0 and set q32_valid=1.
REQ-027 If reset=0 and load=1 occur on the same edge, reset SHALL win.

Reset
REQ-028 While reset=0 at a rising clk, q32 SHALL become 32'h0000_0000 and q32_valid SHALL become 0.
REQ-029 Reset SHALL have no asynchronous effect: q32 and q32_valid change only on a rising clk.
REQ-030 Reset asserted mid-operation SHALL discard the captured value at the next edge.
REQ-031 The combinational outputs d4, d8 and d32 SHALL continue to follow their inputs during reset.

Verification
REQ-032 Bench SHALL drive en5=0 and sweep sel5 0..31 -> d32 = 32'h0000_0000 for every value.
REQ-033 Bench SHALL drive en5=1 and sweep sel5 0..31 -> d32 = 32'h0000_0001 << sel5 for every value (e.g. sel5=5'd31 -> 32'h8000_0000).
REQ-034 Bench SHALL sweep en2 in {0,1} x sel2 0..3 and en3 in {0,1} x sel3 0..7 -> d4 and d8 are zero when disabled and 1<<sel when enabled (e.g. sel3=3'd6 -> d8 = 8'h40).
REQ-035 Bench SHALL set en5=1, sel5=5'd9 with load=1 for one edge -> q32 = 32'h0000_0200 and q32_valid=1 exactly one cycle later, then hold with load=0.
REQ-036 Bench SHALL assert reset=0 while load=1 after a prior capture -> q32 = 0 and q32_valid = 0 after the edge, while d32 still follows sel5.
REQ-037 Bench SHALL build with REG_OUT=0 -> q32 = 0 and q32_valid = 0 constantly, and combinational behaviour is identical to REG_OUT=1.

Source files
------------

// File: rtl/decoder_2to4_3to8.sv
// Standalone 2:4 and 3:8 decoders plus a cascaded 5:32 decoder built from
// the same sub-decoders, with an optional load-captured copy of the 5:32 result.

module dec_2to4 (
  input  logic [1:0] sel_i,
  input  logic       en_i,
  output logic [3:0] d_o
);
  always_comb begin
    d_o = '0;
    if (en_i) d_o[sel_i] = 1'b1;
  end
endmodule

module dec_3to8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] d_o
);
  always_comb begin
    d_o = '0;
    if (en_i) d_o[sel_i] = 1'b1;
  end
endmodule

module decoder_2to4_3to8 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel2,
  input  logic        en2,
  output logic [3:0]  d4,
  input  logic [2:0]  sel3,
  input  logic        en3,
  output logic [7:0]  d8,
  input  logic [4:0]  sel5,
  input  logic        en5,
  output logic [31:0] d32,
  input  logic        load,
  output logic [31:0] q32,
  output logic        q32_valid
);
  logic [3:0] en_mid;

  dec_2to4 u_d4  (.sel_i(sel2),       .en_i(en2), .d_o(d4));
  dec_3to8 u_d8  (.sel_i(sel3),       .en_i(en3), .d_o(d8));

  // Upper select bits pick which byte lane's 3:8 decoder is enabled.
  dec_2to4 u_mid (.sel_i(sel5[4:3]),  .en_i(en5), .d_o(en_mid));

  for (genvar i = 0; i < 4; i++) begin : g_casc
    dec_3to8 u_lane (.sel_i(sel5[2:0]), .en_i(en_mid[i]), .d_o(d32[8*i +: 8]));
  end

  if (REG_OUT) begin : g_reg
    logic [31:0] q32_q, q32_d;
    logic        vld_q, vld_d;

    always_comb begin
      q32_d = q32_q;
      vld_d = vld_q;
      if (load) begin
        q32_d = d32;
        vld_d = 1'b1;
      end
    end

    // Reset is sampled on the edge and takes priority over load.
    always_ff @(posedge clk) begin
      if (!reset) begin
        q32_q <= '0;
        vld_q <= 1'b0;
      end else begin
        q32_q <= q32_d;
        vld_q <= vld_d;
      end
    end

    assign q32       = q32_q;
    assign q32_valid = vld_q;
  end else begin : g_noreg
    logic unused_reg_in;
    assign unused_reg_in = ^{clk, reset, load};
    assign q32       = '0;
    assign q32_valid = 1'b0;
  end
endmodule

// File: tb/tb_decoder_2to4_3to8.sv
// Randomized and directed bench for decoder_2to4_3to8; both REG_OUT builds run
// side by side on shared inputs against a behavioural model.

module tb_decoder_2to4_3to8;
  logic        clk = 1'b0;
  logic        reset, en2, en3, en5, load;
  logic [1:0]  sel2;
  logic [2:0]  sel3;
  logic [4:0]  sel5;
  logic [3:0]  d4,  d4_n;
  logic [7:0]  d8,  d8_n;
  logic [31:0] d32, d32_n, q32, q32_n;
  logic        q32_valid, q32_valid_n;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_q = '0;
  logic        m_v = 1'b0;

  always #5 clk = ~clk;

  decoder_2to4_3to8 #(.REG_OUT(1'b1)) dut (
    .clk(clk), .reset(reset), .sel2(sel2), .en2(en2), .d4(d4),
    .sel3(sel3), .en3(en3), .d8(d8), .sel5(sel5), .en5(en5), .d32(d32),
    .load(load), .q32(q32), .q32_valid(q32_valid));

  decoder_2to4_3to8 #(.REG_OUT(1'b0)) dut_n (
    .clk(clk), .reset(reset), .sel2(sel2), .en2(en2), .d4(d4_n),
    .sel3(sel3), .en3(en3), .d8(d8_n), .sel5(sel5), .en5(en5), .d32(d32_n),
    .load(load), .q32(q32_n), .q32_valid(q32_valid_n));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int n, input logic en);
    longint v;
    v = en ? (64'd2 ** n) : 64'd0;
    return v[31:0];
  endfunction

  // Model of the capture register: what the spec says the edge must do.
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      m_q <= '0;
      m_v <= 1'b0;
    end else if (load === 1'b1) begin
      m_q <= onehot(int'(sel5), en5);
      m_v <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d4",        {28'd0, d4},   onehot(int'(sel2), en2));
      chk("d8",        {24'd0, d8},   onehot(int'(sel3), en3));
      chk("d32",       d32,           onehot(int'(sel5), en5));
      chk("q32",       q32,           m_q);
      chk("q32_valid", {31'd0, q32_valid}, {31'd0, m_v});
      chk("n_d4",      {28'd0, d4_n}, onehot(int'(sel2), en2));
      chk("n_d8",      {24'd0, d8_n}, onehot(int'(sel3), en3));
      chk("n_d32",     d32_n,         onehot(int'(sel5), en5));
      chk("n_q32",     q32_n,         32'h0);
      chk("n_valid",   {31'd0, q32_valid_n}, 32'h0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0;
    en2 = 1'b0; en3 = 1'b0; en5 = 1'b0;
    sel2 = '0; sel3 = '0; sel5 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_q32",   q32, 32'h0);
    chk("rst_valid", {31'd0, q32_valid}, 32'h0);
    next_cycle();
    reset = 1'b1;

    // Exhaustive select sweeps, enables off then on.
    for (int e = 0; e < 2; e++) begin
      for (int s = 0; s < 32; s++) begin
        en5 = e[0]; sel5 = s[4:0];
        en2 = e[0]; sel2 = s[1:0];
        en3 = e[0]; sel3 = s[2:0];
        @(negedge clk);
        if (e == 1 && s == 31) chk("lit_d32_31", d32, 32'h8000_0000);
        if (e == 1 && s == 6)  chk("lit_d8_6",   {24'd0, d8}, 32'h40);
        if (e == 0 && s == 17) chk("lit_d32_off", d32, 32'h0);
        next_cycle();
      end
    end

    // Single capture with 1-cycle latency, then hold.
    en5 = 1'b1; sel5 = 5'd9; load = 1'b1;
    @(negedge clk);
    chk("lit_prelat", q32, 32'h0);
    next_cycle();
    load = 1'b0; sel5 = 5'd4;
    @(negedge clk);
    chk("lit_cap",   q32, 32'h0000_0200);
    chk("lit_cap_v", {31'd0, q32_valid}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("lit_hold",  q32, 32'h0000_0200);

    // Reset with load on the same edge; no asynchronous effect before it.
    next_cycle();
    reset = 1'b0; load = 1'b1; sel5 = 5'd3;
    #2;
    chk("lit_async", q32, 32'h0000_0200);
    next_cycle();
    chk("lit_rst_q",  q32, 32'h0);
    chk("lit_rst_v",  {31'd0, q32_valid}, 32'h0);
    chk("lit_rst_d32", d32, 32'h8);

    // Load with the cascade disabled captures zero but marks valid.
    reset = 1'b1; en5 = 1'b0; load = 1'b1;
    next_cycle();
    load = 1'b0;
    chk("lit_en0_q", q32, 32'h0);
    chk("lit_en0_v", {31'd0, q32_valid}, 32'h1);

    for (int i = 0; i < 400; i++) begin
      next_cycle();
      reset = ($urandom_range(0, 15) != 0);
      load  = $urandom_range(0, 1);
      en2 = $urandom_range(0, 1); sel2 = 2'($urandom);
      en3 = $urandom_range(0, 1); sel3 = 3'($urandom);
      en5 = ($urandom_range(0, 3) != 0); sel5 = 5'($urandom);
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
